// File: rtl/ext_pkg.sv
// ---------------------------------------------------------------------------
// ext_pkg
// Shared definitions for the immediate-extension / target-generation unit
// that sits on the ID->EX boundary of the MIPS32 pipeline.
//   - op encodings for the five extension modes (5-7 are reserved)
//   - default widths used by ext_core and ext_pipe
//   - the layout of one held pipeline entry at default width
// ---------------------------------------------------------------------------
package ext_pkg;

    // Extension mode encodings carried on the 3-bit op field
    localparam logic [2:0] OP_ZERO   = 3'd0;
    localparam logic [2:0] OP_SIGN   = 3'd1;
    localparam logic [2:0] OP_LUI    = 3'd2;
    localparam logic [2:0] OP_BRANCH = 3'd3;
    localparam logic [2:0] OP_JUMP   = 3'd4;

    // Default widths: result/PC, I-type immediate, J-type index
    localparam int EXT_DATA_W = 32;
    localparam int EXT_IMM_W  = 16;
    localparam int EXT_JIMM_W = 26;

    // One held entry at default width: {valid, ext, err}
    typedef struct packed {
        logic                  valid;
        logic [EXT_DATA_W-1:0] ext;
        logic                  err;
    } ext_entry_t;

    // Every code above OP_JUMP is reserved
    function automatic logic isReservedOp(input logic [2:0] op);
        return op > OP_JUMP;
    endfunction

endpackage

// File: rtl/ext_core.sv
// ---------------------------------------------------------------------------
// ext_core
// Purely combinational extension datapath.
// Ports:
//   i_imm  [JIMM_W-1:0]  raw immediate field (I-type uses the low IMM_W bits)
//   i_pc   [DATA_W-1:0]  PC of the instruction
//   i_op   [2:0]         extension mode
//   o_ext  [DATA_W-1:0]  extended value / generated target (0 for reserved)
//   o_err                high for reserved op codes
// ---------------------------------------------------------------------------
module ext_core
    import ext_pkg::*;
#(
    parameter int DATA_W = EXT_DATA_W,
    parameter int IMM_W  = EXT_IMM_W,
    parameter int JIMM_W = EXT_JIMM_W
) (
    input  logic [JIMM_W-1:0] i_imm,
    input  logic [DATA_W-1:0] i_pc,
    input  logic [2:0]        i_op,
    output logic [DATA_W-1:0] o_ext,
    output logic              o_err
);

    // Bits of pc+4 below this mask are replaced by the jump index and the
    // two word-alignment zeros; shifting by DATA_W yields 0, so the mask
    // degenerates to all ones when the index fills the whole word.
    localparam logic [DATA_W-1:0] J_LOW_MASK =
        (DATA_W'(1) << (JIMM_W + 2)) - DATA_W'(1);

    logic [IMM_W-1:0]  w_immI;
    logic [DATA_W-1:0] w_zext;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_pcPlus4;
    logic [DATA_W-1:0] w_jIdx;

    assign w_immI    = i_imm[IMM_W-1:0];
    assign w_zext    = DATA_W'(w_immI);
    assign w_sext    = DATA_W'($signed(w_immI));
    assign w_pcPlus4 = i_pc + DATA_W'(4);
    assign w_jIdx    = DATA_W'(i_imm) << 2;

    // Mode select. LUI reuses the zero-extended value shifted to the top;
    // branch offsets are word offsets, so the sign-extended value is scaled
    // by 4 and the sum wraps silently.
    always_comb begin
        o_ext = '0;
        o_err = 1'b0;
        case (i_op)
            OP_ZERO:   o_ext = w_zext;
            OP_SIGN:   o_ext = w_sext;
            OP_LUI:    o_ext = w_zext << (DATA_W - IMM_W);
            OP_BRANCH: o_ext = w_pcPlus4 + (w_sext << 2);
            OP_JUMP:   o_ext = (w_pcPlus4 & ~J_LOW_MASK) | w_jIdx;
            default:   o_err = isReservedOp(i_op);
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// ---------------------------------------------------------------------------
// ext_pipe
// Pipelined immediate-extension unit with a valid/ready handshake and a
// 2-entry skid buffer (main + skid), so in_ready comes straight from a flop.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   flush                 synchronous flush, discards all held entries
//   in_valid / in_ready   producer handshake (in_ready registered)
//   imm [JIMM_W-1:0]      raw immediate field
//   pc  [DATA_W-1:0]      PC of the instruction
//   op  [2:0]             extension mode (5-7 reserved)
//   out_valid / out_ready consumer handshake
//   ext [DATA_W-1:0]      result held in the main entry
//   out_err               main entry came from a reserved op
//   err_cnt [CNT_W-1:0]   saturating count of accepted reserved ops
// ---------------------------------------------------------------------------
module ext_pipe
    import ext_pkg::*;
#(
    parameter int DATA_W = EXT_DATA_W,
    parameter int IMM_W  = EXT_IMM_W,
    parameter int JIMM_W = EXT_JIMM_W,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [JIMM_W-1:0] imm,
    input  logic [DATA_W-1:0] pc,
    input  logic [2:0]        op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ext,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_cnt
);

    // Same layout as ext_entry_t, sized by this instance's DATA_W
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] ext;
        logic              err;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    entry_t            r_main;
    entry_t            r_skid;
    logic              r_inReady;
    logic [CNT_W-1:0]  r_errCnt;

    entry_t            w_mainNext;
    entry_t            w_skidNext;
    entry_t            w_newEntry;
    logic [CNT_W-1:0]  w_errCntNext;
    logic [DATA_W-1:0] w_coreExt;
    logic              w_coreErr;
    logic              w_accept;
    logic              w_retire;

    // The result is computed at accept time and captured into an entry
    ext_core #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W),
        .JIMM_W (JIMM_W)
    ) u_core (
        .i_imm (imm),
        .i_pc  (pc),
        .i_op  (op),
        .o_ext (w_coreExt),
        .o_err (w_coreErr)
    );

    assign w_accept   = in_valid && r_inReady;
    assign w_retire   = r_main.valid && out_ready;
    assign w_newEntry = '{valid: 1'b1, ext: w_coreExt, err: w_coreErr};

    // Skid-buffer steering. When the main slot frees up (empty or retiring)
    // a waiting skid entry always moves up first to keep FIFO order, and a
    // new input lands behind it. Invalidating an entry only clears its valid
    // bit so the data fields hold their last value.
    always_comb begin
        w_mainNext   = r_main;
        w_skidNext   = r_skid;
        w_errCntNext = r_errCnt;
        if (!r_main.valid || w_retire) begin
            if (r_skid.valid) begin
                w_mainNext       = r_skid;
                w_skidNext.valid = 1'b0;
                if (w_accept) begin
                    w_skidNext = w_newEntry;
                end
            end else begin
                w_mainNext.valid = 1'b0;
                if (w_accept) begin
                    w_mainNext = w_newEntry;
                end
            end
        end else if (w_accept) begin
            w_skidNext = w_newEntry;
        end
        if (w_accept && w_coreErr && (r_errCnt != CNT_MAX)) begin
            w_errCntNext = r_errCnt + CNT_W'(1);
        end
    end

    // State update. Reset wins over flush; flush drops both entries and any
    // same-cycle input but leaves the error count and held data alone.
    // in_ready is the inverse of the next skid valid, so a full buffer
    // never accepts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_main    <= '0;
            r_skid    <= '0;
            r_inReady <= 1'b1;
            r_errCnt  <= '0;
        end else if (flush) begin
            r_main.valid <= 1'b0;
            r_skid.valid <= 1'b0;
            r_inReady    <= 1'b1;
        end else begin
            r_main    <= w_mainNext;
            r_skid    <= w_skidNext;
            r_inReady <= !w_skidNext.valid;
            r_errCnt  <= w_errCntNext;
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_main.valid;
    assign ext       = r_main.ext;
    assign out_err   = r_main.err;
    assign err_cnt   = r_errCnt;

endmodule
